// File: rtl/cbus_clint.sv
// CBus core-local interruptor: msip / mtimecmp / mtime registers behind a
// single-address burst slave, driving the core's timer and software interrupts.

package cbus_clint_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

// Handshake: a request is accepted on the edge where creq.valid=1 in IDLE.
// The slave then presents len+1 beats, one per cycle with cresp.ready=1,
// cresp.last=1 on the final one; the master must hold creq stable meanwhile.
module cbus_clint
  import cbus_clint_pkg::*;
#(
  parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp,
  output logic       trint,
  output logic       swint
);

  localparam logic [15:0] OFF_MSIP     = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
  localparam logic [15:0] OFF_MTIME    = 16'hBFF8;
  localparam logic [15:0] TICK_MAX     = 16'(TICK_DIV - 1);

  typedef enum logic {S_IDLE, S_BEAT} state_e;

  state_e      state_q, state_d;
  logic [15:0] off_q, off_d;
  logic        wr_q, wr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        msip_q, msip_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0] mtime_q, mtime_d;
  logic [15:0] presc_q, presc_d;

  logic        tick;
  logic        wr_beat;
  logic [63:0] rdata;

  // Only the low 16 address bits select a register; the rest is the base.
  logic unused_ok;
  assign unused_ok = ^{BASE, creq.addr[63:16], creq.addr[2:0], creq.size, creq.burst};

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  strb);
    logic [63:0] r;
    r = old_v;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    rdata = '0;
    case (off_q)
      OFF_MSIP:     rdata = {63'd0, msip_q};
      OFF_MTIMECMP: rdata = mtimecmp_q;
      OFF_MTIME:    rdata = mtime_q;
      default:      rdata = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    wr_d    = wr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    cresp   = '0;
    case (state_q)
      S_IDLE: begin
        if (creq.valid) begin
          off_d   = {creq.addr[15:3], 3'b000};
          wr_d    = creq.is_write;
          len_d   = creq.len;
          cnt_d   = '0;
          state_d = S_BEAT;
        end
      end
      S_BEAT: begin
        cresp.ready = 1'b1;
        cresp.last  = (cnt_q == len_q);
        cresp.data  = wr_q ? 64'd0 : rdata;
        cnt_d       = cnt_q + 8'd1;
        if (cnt_q == len_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A bus write to mtime overrides the tick for that cycle; the prescaler
  // keeps running so the tick cadence is unaffected by software writes.
  always_comb begin
    tick       = (presc_q == TICK_MAX);
    presc_d    = tick ? 16'd0 : presc_q + 16'd1;
    wr_beat    = (state_q == S_BEAT) && wr_q;
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr_beat) begin
      case (off_q)
        OFF_MSIP:     if (creq.strobe[0]) msip_d = creq.data[0];
        OFF_MTIMECMP: mtimecmp_d = merge_bytes(mtimecmp_q, creq.data, creq.strobe);
        OFF_MTIME:    mtime_d = merge_bytes(mtime_q, creq.data, creq.strobe);
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      off_q      <= '0;
      wr_q       <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      msip_q     <= 1'b0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtime_q    <= '0;
      presc_q    <= '0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      wr_q       <= wr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      mtime_q    <= mtime_d;
      presc_q    <= presc_d;
    end
  end

  assign trint = (mtime_q >= mtimecmp_q);
  assign swint = msip_q;

endmodule

// File: tb/tb_cbus_clint.sv
// Scoreboard bench for cbus_clint: randomized and directed bus traffic checked
// against an elapsed-cycle model of mtime plus plain msip/mtimecmp variables.

module tb_cbus_clint;
  import cbus_clint_pkg::*;

  localparam int EW = 64 + 1 + 64;  // {beat cycle, last, data}
  localparam logic [15:0] A_MSIP = 16'h0000;
  localparam logic [15:0] A_CMP  = 16'h4000;
  localparam logic [15:0] A_MT   = 16'hBFF8;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  cbus_req_t  creq  = '0;
  cbus_resp_t cresp;
  logic       trint, swint;

  cbus_clint #(.TICK_DIV(1)) dut (
    .clk  (clk),
    .reset(reset),
    .creq (creq),
    .cresp(cresp),
    .trint(trint),
    .swint(swint)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  logic [63:0] cyc = '0;  // rising edges since reset released
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + 64'd1;
  end

  // ---------------- reference model ----------------
  // mtime after edge e is mt_base + (e - mt_edge) with one tick per cycle.
  logic [63:0] mt_base = '0, mt_edge = '0, cmp_m = '1;
  logic        msip_m = 1'b0;

  function automatic logic [63:0] mt_at(input logic [63:0] e);
    return mt_base + (e - mt_edge);
  endfunction

  function automatic logic [63:0] merge_m(input logic [63:0] o, input logic [63:0] d,
                                          input logic [7:0] s);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    mt_base = '0; mt_edge = '0; cmp_m = '1; msip_m = 1'b0;
  endtask

  // Called just after the edge that commits the first write beat.
  task automatic model_write(input logic [15:0] off, input logic [7:0] s, input logic [63:0] d);
    case (off)
      A_MSIP: if (s[0]) msip_m = d[0];
      A_CMP:  cmp_m = merge_m(cmp_m, d, s);
      A_MT: begin
        mt_base = merge_m(mt_at(cyc - 64'd1), d, s);
        mt_edge = cyc;
      end
      default: ;
    endcase
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0, errors = 0;
  logic done = 1'b0, timeout = 1'b0;
  int async_id = 0, async_seen = 0;
  logic [1:0] async_smp = '0;  // {ready before reset, ready just after reset}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (async_id != async_seen) begin
      check("midburst_ready_before_rst", 64'(async_smp[1]), 64'd1);
      check("async_ready_drop", 64'(async_smp[0]), 64'd0);
      async_seen = async_id;
    end
    if (reset) begin
      check("rst_ready", 64'(cresp.ready), 64'd0);
      check("rst_last", 64'(cresp.last), 64'd0);
      check("rst_data", cresp.data, 64'd0);
      check("rst_trint", 64'(trint), 64'd0);
      check("rst_swint", 64'(swint), 64'd0);
    end else begin
      check("swint", 64'(swint), 64'(msip_m));
      check("trint", 64'(trint), 64'(mt_at(cyc) >= cmp_m));
      if (cresp.ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got ready=1 expected no beat (cyc %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("beat_cycle", cyc, e[128:65]);
          check("beat_last", 64'(cresp.last), 64'(e[64]));
          check("beat_data", cresp.data, e[63:0]);
        end
      end else begin
        check("idle_last", 64'(cresp.last), 64'd0);
        check("idle_data", cresp.data, 64'd0);
      end
    end
    if (timeout) begin
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
    if (done) begin
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #200000;
    timeout = 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    creq  = '0;
    model_reset();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Entered and left 1 time unit after a rising edge, with the slave idle.
  task automatic do_req(input logic w, input logic [63:0] addr, input logic [7:0] strb,
                        input logic [63:0] data, input logic [7:0] len);
    logic [63:0] c, rd;
    logic [15:0] off;
    off = {addr[15:3], 3'b000};
    c   = cyc;
    creq.valid    = 1'b1;
    creq.is_write = w;
    creq.size     = 3'd3;
    creq.addr     = addr;
    creq.strobe   = strb;
    creq.data     = data;
    creq.len      = len;
    creq.burst    = 2'($urandom_range(0, 2));
    for (int i = 0; i <= int'(len); i++) begin
      rd = '0;
      if (!w) begin
        case (off)
          A_MSIP:  rd = {63'd0, msip_m};
          A_CMP:   rd = cmp_m;
          A_MT:    rd = mt_at(c + 64'd1 + 64'(i));
          default: rd = '0;
        endcase
      end
      exp_q.push_back({c + 64'd1 + 64'(i), (i == int'(len)), rd});
    end
    idle(1);
    for (int i = 0; i <= int'(len); i++) begin
      idle(1);
      if (i == 0 && w) model_write(off, strb, data);
    end
    creq.valid = 1'b0;
  endtask

  function automatic logic [63:0] base_addr(input logic [15:0] off);
    return {48'h0000_0000_0200, off};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] off;
    logic [63:0] a;
    logic        w;
    logic [7:0]  len;
    int          k;

    do_reset();
    do_req(1'b0, base_addr(A_MT), 8'h00, 64'd0, 8'd0);          // mtime = elapsed cycles
    do_req(1'b1, base_addr(A_CMP), 8'hFF, 64'd100, 8'd0);       // timer fires at 100
    while (cyc < 64'd110) idle(1);

    do_req(1'b1, base_addr(A_MSIP), 8'h01, 64'd1, 8'd0);
    do_req(1'b0, base_addr(A_MSIP), 8'h00, 64'd0, 8'd0);
    do_req(1'b1, base_addr(A_MSIP), 8'hFE, 64'd0, 8'd0);        // no strobe[0]: no change
    do_req(1'b1, base_addr(A_MSIP), 8'h01, 64'hFFFF_FFFF_FFFF_FFFE, 8'd0);
    do_req(1'b0, base_addr(A_MSIP), 8'h00, 64'd0, 8'd0);

    do_req(1'b1, base_addr(A_CMP), 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'd0);
    do_req(1'b1, base_addr(A_MT), 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, 8'd0);
    do_req(1'b0, base_addr(A_MT), 8'h00, 64'd0, 8'd2);          // ...FFFF then wrap
    idle(3);
    do_req(1'b1, base_addr(A_MT), 8'h0C, 64'h0000_0000_5A5A_0000, 8'd0);

    do_req(1'b1, base_addr(A_CMP), 8'h3C, 64'h1234_5678_9ABC_DEF0, 8'd1);
    do_req(1'b0, base_addr(A_CMP), 8'h00, 64'd0, 8'd3);         // 4-beat read burst
    do_req(1'b1, base_addr(16'h1000), 8'hFF, 64'd7, 8'd3);      // unmapped write
    do_req(1'b0, base_addr(16'h1000), 8'h00, 64'd0, 8'd3);
    do_req(1'b0, base_addr(A_CMP), 8'h00, 64'd0, 8'd0);

    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 3);
      case (k)
        0: off = A_MSIP;
        1: off = A_CMP;
        2: off = A_MT;
        default: begin
          do off = 16'($urandom);
          while ((off & 16'hFFF8) == A_MSIP || (off & 16'hFFF8) == A_CMP ||
                 (off & 16'hFFF8) == A_MT);
        end
      endcase
      a = {$urandom, $urandom};
      a[15:0] = {off[15:3], 3'($urandom_range(0, 7))};
      w   = 1'($urandom_range(0, 1));
      len = (w && k == 2) ? 8'd0 : 8'($urandom_range(0, 3));
      do_req(w, a, 8'($urandom), {$urandom, $urandom}, len);
      idle($urandom_range(0, 2));
    end

    // Reset during the second beat of a write burst.
    do_req(1'b1, base_addr(A_MSIP), 8'h01, 64'd1, 8'd0);
    creq.valid = 1'b1; creq.is_write = 1'b1; creq.addr = base_addr(A_CMP);
    creq.strobe = 8'hFF; creq.data = 64'd5; creq.len = 8'd3; creq.size = 3'd3;
    exp_q.push_back({cyc + 64'd1, 1'b0, 64'd0});
    idle(1);
    idle(1);
    model_write(A_CMP, 8'hFF, 64'd5);
    async_smp[1] = cresp.ready;
    #1;
    reset = 1'b1;
    model_reset();
    exp_q.delete();
    creq = '0;
    #1;
    async_smp[0] = cresp.ready;
    async_id++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    do_req(1'b0, base_addr(A_CMP), 8'h00, 64'd0, 8'd0);
    do_req(1'b0, base_addr(A_MSIP), 8'h00, 64'd0, 8'd0);
    do_req(1'b0, base_addr(A_MT), 8'h00, 64'd0, 8'd1);

    idle(3);
    done = 1'b1;
  end

endmodule

// File: doc/cbus_clint.md
CBUS_CLINT -- requirements
Module: cbus_clint

Interface
REQ-001 SHALL have parameter BASE, default 64'h0000_0000_0200_0000, the CLINT base address; only addr[15:0] is decoded.
REQ-002 SHALL have parameter TICK_DIV, default 1, the clock cycles per mtime increment; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port creq  input  cbus_req_t  CBus request: valid, is_write, size, addr, strobe, data, len, burst.
REQ-006 SHALL have port cresp  output  cbus_resp_t  CBus response: ready, last, data.
REQ-007 SHALL have port trint  output  1  timer interrupt, to the core's trint.
REQ-008 SHALL have port swint  output  1  software interrupt, to the core's swint.

Function
REQ-009 SHALL hold three registers: msip (1 bit), mtimecmp (64 bits) and mtime (64 bits).
REQ-010 SHALL decode offset = addr[15:0] with bits [2:0] cleared: 16'h0000 is msip, 16'h4000 is mtimecmp, 16'hBFF8 is mtime; every other offset is unmapped.
REQ-011 SHALL implement FSM IDLE -> BEAT -> IDLE.
REQ-012 SHALL, in IDLE with creq.valid=1, latch addr, is_write and len, clear the beat counter, and enter BEAT on the next edge; cresp.ready SHALL be 0 in IDLE.
REQ-013 SHALL, in BEAT, drive cresp.ready=1 every cycle, giving a first-beat latency of exactly 1 cycle after request acceptance.
REQ-014 SHALL, in BEAT, increment the beat counter each cycle and drive cresp.last=1 when the counter equals the latched len.
REQ-015 SHALL return to IDLE on the edge ending the last beat; a new request SHALL NOT be accepted earlier than 1 cycle after that.
REQ-016 SHALL apply every beat to the same latched address; no address increment, for any burst type.
REQ-017 SHALL, on a read beat, drive cresp.data with the current register value: msip zero-extended, mtime, mtimecmp, or 0 when unmapped.
REQ-018 SHALL, on a write beat, update only the bytes whose creq.strobe bit is 1, using creq.data sampled that cycle.
REQ-019 SHALL write msip only from strobe[0] and data[0]; all other msip bits read as 0.
REQ-020 SHALL ignore writes to unmapped offsets while still completing the full handshake.
REQ-021 SHALL drive cresp.data=0 in IDLE and on write beats.
REQ-022 SHALL use a prescaler counting 0..TICK_DIV-1; mtime increments by 1 on the cycle the prescaler wraps.
REQ-023 SHALL wrap mtime from 64'hFFFF_FFFF_FFFF_FFFF to 0 without any flag.
REQ-024 SHALL give a CBus write to mtime priority over the tick increment in the same cycle; unstrobed bytes keep their pre-increment value.
REQ-025 SHALL NOT reset the prescaler on an mtime write.
REQ-026 SHALL drive trint = (mtime >= mtimecmp), an unsigned comparison of the register outputs; trint SHALL be combinational from registers and change the cycle after either register updates.
REQ-027 SHALL drive swint = msip.
REQ-028 SHALL leave behaviour undefined if creq changes or is deasserted during BEAT (protocol violation); no recovery is required.

Reset
REQ-029 SHALL, on reset assertion, immediately set: FSM=IDLE, beat counter=0, prescaler=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0.
REQ-030 SHALL therefore drive cresp.ready=0, cresp.last=0, cresp.data=0, trint=0 and swint=0 asynchronously while reset is high.
REQ-031 SHALL abandon any in-flight burst on reset mid-BEAT with no partial-beat side effects; writes from already completed beats are retained until the register reset takes effect.
REQ-032 SHALL start counting mtime on the first clock edge after reset deasserts.

Verification
REQ-033 SHALL cover: TICK_DIV=1, reset, then read mtime at offset BFF8 -> cresp.ready 1 cycle after acceptance, last=1, data equals the elapsed cycle count.
REQ-034 SHALL cover: write mtimecmp=64'd100 with strobe 8'hFF, mtime near 0 -> trint=0 until mtime reaches 100, then trint=1 on that same cycle.
REQ-035 SHALL cover: write msip with data=1, strobe=8'h01, then data=0 -> swint rises the cycle after the first write beat and falls after the second; a read returns 64'h1, then 0.
REQ-036 SHALL cover: write mtime=64'hFFFF_FFFF_FFFF_FFFE, TICK_DIV=1 -> mtime reads ...FFFF then wraps to 0; with mtimecmp=...FFFF, trint drops to 0 at the wrap.
REQ-037 SHALL cover: 4-beat read burst (len=3) to 16'h4000 -> exactly 4 ready cycles, last only on the 4th, identical data each beat; a burst to unmapped offset 16'h1000 returns 0 with no state change.
REQ-038 SHALL cover: reset asserted on the 2nd beat of a write burst -> cresp.ready drops without waiting for an edge; after release all registers are at reset values and a new request is accepted normally.
